cmd_scheduler: RTL
==================

Name: cmd_scheduler

Overview:
- Sequences commands decoded by the UART command selector (address byte + request byte + done pulse) onto N sensor units.
- Queues commands, validates them and dispatches them one at a time to the addressed sensor.
- Waits for that sensor's completion or a timeout, then drives a 2-byte response (status, data) into the UART transmitter.
- Sits between the selector and the sensor/TX blocks in the FPGA I/O interface top level.

Parameters:
- N_SENSORS, 8, number of sensor units; valid addresses are 0..N_SENSORS-1.
- MAX_REQ, 7, valid request codes are 0x01..MAX_REQ.
- FIFO_DEPTH, 4, command queue entries; power of two, at least 2.
- TIMEOUT_CYCLES, 50000000, cycles to wait for sensor done before reporting a timeout.

Ports:
- i_Clock  in  1  system clock.
- i_Rst  in  1  asynchronous reset, active-high.
- i_Cmd_Valid  in  1  one-cycle pulse from the selector; address and request are valid in the same cycle.
- i_Address  in  8  sensor address.
- i_Request  in  8  request code.
- o_Sensor_Start  out  N_SENSORS  one-hot start, single-cycle pulse.
- o_Sensor_Req  out  8  request code; held stable from start until done or timeout.
- i_Sensor_Done  in  N_SENSORS  per-sensor one-cycle done pulse.
- i_Sensor_Data  in  8  shared sensor result; sampled with the selected sensor's done.
- o_Tx_Start  out  1  one-cycle pulse to the UART TX.
- o_Tx_Byte  out  8  byte to transmit; held stable until i_Tx_Done.
- i_Tx_Busy  in  1  TX is currently sending.
- i_Tx_Done  in  1  one-cycle pulse at the end of a byte.
- o_Busy  out  1  high in any state other than IDLE.
- o_Overflow  out  1  sticky flag: a command was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous): all outputs are 0, the FIFO is empty, the FSM is in IDLE, the timeout counter is 0, and o_Overflow is cleared.
- Reset mid-transaction aborts the transaction. No response is sent.
- FIFO:
  - i_Cmd_Valid pushes {address, request}.
  - If the FIFO is full and no pop occurs in the same cycle, the command is dropped and o_Overflow is set. o_Overflow clears only on reset.
  - A push and a pop in the same cycle while full is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if the FIFO is not empty, go to POP.
  - POP: latch the head entry, pop it, validate it.
    - Address >= N_SENSORS: status 0xE0, data 0x00, go to RESP_STAT.
    - Else request == 0 or request > MAX_REQ: status 0xE1, data 0x00, go to RESP_STAT.
    - Else go to START.
  - START: pulse o_Sensor_Start[addr] for 1 cycle, drive o_Sensor_Req, clear the counter, go to WAIT.
  - WAIT:
    - i_Sensor_Done[addr]: capture i_Sensor_Data, status 0x1F, go to RESP_STAT.
    - Else counter reaches TIMEOUT_CYCLES-1: status 0xE2, data 0x00, go to RESP_STAT.
    - Done and timeout in the same cycle: done wins.
    - Done pulses from non-selected sensors are ignored.
  - RESP_STAT: when i_Tx_Busy is 0, set o_Tx_Byte to status, pulse o_Tx_Start, go to WAIT_STAT.
  - WAIT_STAT: on i_Tx_Done go to RESP_DATA.
  - RESP_DATA: when i_Tx_Busy is 0, set o_Tx_Byte to data, pulse o_Tx_Start, go to WAIT_DATA.
  - WAIT_DATA: on i_Tx_Done go to IDLE.
- Latency:
  - Empty FIFO + valid command: o_Sensor_Start pulses 3 cycles after i_Cmd_Valid (push, IDLE->POP, POP->START).
  - Invalid command: o_Tx_Start is asserted 3 cycles after i_Cmd_Valid.
- Commands arriving while busy are queued and served strictly in FIFO order.
- TX backpressure: the FSM waits indefinitely in RESP_* while i_Tx_Busy is 1 (no timeout on TX).

Optional Feature:
- Macro: CMD_SCHED_ECHO_EN.
- Defined: the response is 3 bytes (address echo, status, data). A RESP_ADDR/WAIT_ADDR pair is inserted before RESP_STAT using the same TX handshake. On invalid commands the echo carries the raw received address.
- Undefined: the response is 2 bytes as above.

Test Plan:
- Push addr 0x03, req 0x01; sensor 3 done after 10 cycles with data 0x5A -> start pulse on bit 3 only, o_Sensor_Req=0x01, TX bytes 0x1F then 0x5A, o_Busy falls after the second i_Tx_Done.
- Push addr 0x09 (N_SENSORS=8) -> no sensor start; TX 0xE0, 0x00. Push addr 0x02, req 0x00 -> TX 0xE1, 0x00.
- TIMEOUT_CYCLES=20, addr 0x01, req 0x02, no done -> TX 0xE2, 0x00 exactly 20 cycles after start. Variant: done and timeout in the same cycle -> status 0x1F.
- Send 6 valid commands back-to-back while the first is in WAIT (FIFO_DEPTH=4) -> 4 queued, 1 dropped, o_Overflow=1; the queued commands are served in order (check addresses via start bits).
- Hold i_Tx_Busy=1 for 50 cycles at RESP_STAT -> no o_Tx_Start until busy falls; o_Tx_Byte is stable throughout. Done pulse from sensor 5 while waiting on sensor 2 -> ignored.
- Assert i_Rst during WAIT -> all outputs 0 immediately, FIFO empty, no TX afterwards; with CMD_SCHED_ECHO_EN, addr 0x04 -> TX 0x04, 0x1F, data.

Source files
------------

// File: rtl/cmd_scheduler.sv
// cmd_scheduler
//   Queues {address, request} commands from the UART command selector,
//   validates them, dispatches each one to the addressed sensor unit, waits
//   for that sensor's done pulse (or a timeout) and sends the response bytes
//   (status, data) through the UART transmitter handshake.
//
//   Build option: define CMD_SCHED_ECHO_EN to prefix every response with an
//   echo of the received address byte (3-byte response instead of 2).
//
// Ports:
//   i_Clock         system clock
//   i_Rst           asynchronous reset, active-high
//   i_Cmd_Valid     one-cycle command pulse; i_Address/i_Request valid with it
//   i_Address       sensor address
//   i_Request       request code
//   o_Sensor_Start  one-hot, single-cycle start to the addressed sensor
//   o_Sensor_Req    request code, held from start until done/timeout
//   i_Sensor_Done   per-sensor one-cycle done pulse
//   i_Sensor_Data   shared sensor result, sampled with the selected done
//   o_Tx_Start      one-cycle start pulse to the UART TX
//   o_Tx_Byte       byte to transmit, held until i_Tx_Done
//   i_Tx_Busy       TX is sending
//   i_Tx_Done       one-cycle pulse at the end of a byte
//   o_Busy          high whenever the scheduler is not idle
//   o_Overflow      sticky: a command was dropped on a full queue
module cmd_scheduler #(
  parameter int unsigned N_SENSORS      = 8,
  parameter int unsigned MAX_REQ        = 7,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst,
  input  logic                 i_Cmd_Valid,
  input  logic [7:0]           i_Address,
  input  logic [7:0]           i_Request,
  output logic [N_SENSORS-1:0] o_Sensor_Start,
  output logic [7:0]           o_Sensor_Req,
  input  logic [N_SENSORS-1:0] i_Sensor_Done,
  input  logic [7:0]           i_Sensor_Data,
  output logic                 o_Tx_Start,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Busy,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic                 o_Overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [7:0] STAT_OK       = 8'h1F;
  localparam logic [7:0] STAT_BAD_ADDR = 8'hE0;
  localparam logic [7:0] STAT_BAD_REQ  = 8'hE1;
  localparam logic [7:0] STAT_TIMEOUT  = 8'hE2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_POP,
    S_START,
    S_WAIT,
    S_RESP_ADDR,
    S_WAIT_ADDR,
    S_RESP_STAT,
    S_WAIT_STAT,
    S_RESP_DATA,
    S_WAIT_DATA
  } state_t;

`ifdef CMD_SCHED_ECHO_EN
  localparam state_t S_FIRST_RESP = S_RESP_ADDR;
`else
  localparam state_t S_FIRST_RESP = S_RESP_STAT;
`endif

  state_t r_state, w_state_nxt;

  // Command queue
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_full, w_empty, w_push, w_pop;
  logic [7:0]    w_head_addr, w_head_req;

  // Active command and response
  logic [7:0]    r_addr, r_req, r_status, r_data;
  logic [CW-1:0] r_cnt;
  logic [N_SENSORS-1:0] w_sel;
  logic          w_done, w_timeout;
  logic          w_cmd_load, w_resp_load;
  logic [7:0]    w_status_nxt, w_data_nxt;

  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_pop       = (r_state == S_POP);
  // A full queue still accepts when the head leaves in the same cycle.
  assign w_push      = i_Cmd_Valid && (!w_full || w_pop);
  assign w_head_addr = r_mem[r_rd][15:8];
  assign w_head_req  = r_mem[r_rd][7:0];

  always_ff @(posedge i_Clock) begin
    if (w_push) r_mem[r_wr] <= {i_Address, i_Request};
  end

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (i_Cmd_Valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // One-hot decode of the active address; only this sensor's done counts.
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < N_SENSORS; i++) begin
      if (r_addr == 8'(i)) w_sel[i] = 1'b1;
    end
  end

  assign w_done    = |(i_Sensor_Done & w_sel);
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cmd_load     = 1'b0;
    w_resp_load    = 1'b0;
    w_status_nxt   = '0;
    w_data_nxt     = '0;
    o_Sensor_Start = '0;
    o_Sensor_Req   = '0;
    o_Tx_Start     = 1'b0;
    o_Tx_Byte      = '0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_POP;
      end
      S_POP: begin
        w_cmd_load = 1'b1;
        if ({1'b0, w_head_addr} >= 9'(N_SENSORS)) begin
          w_resp_load  = 1'b1;
          w_status_nxt = STAT_BAD_ADDR;
          w_state_nxt  = S_FIRST_RESP;
        end else if (w_head_req == '0 || {1'b0, w_head_req} > 9'(MAX_REQ)) begin
          w_resp_load  = 1'b1;
          w_status_nxt = STAT_BAD_REQ;
          w_state_nxt  = S_FIRST_RESP;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        o_Sensor_Start = w_sel;
        o_Sensor_Req   = r_req;
        w_state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        o_Sensor_Req = r_req;
        if (w_done) begin
          w_resp_load  = 1'b1;
          w_status_nxt = STAT_OK;
          w_data_nxt   = i_Sensor_Data;
          w_state_nxt  = S_FIRST_RESP;
        end else if (w_timeout) begin
          w_resp_load  = 1'b1;
          w_status_nxt = STAT_TIMEOUT;
          w_state_nxt  = S_FIRST_RESP;
        end
      end
`ifdef CMD_SCHED_ECHO_EN
      S_RESP_ADDR: begin
        o_Tx_Byte = r_addr;
        if (!i_Tx_Busy) begin
          o_Tx_Start  = 1'b1;
          w_state_nxt = S_WAIT_ADDR;
        end
      end
      S_WAIT_ADDR: begin
        o_Tx_Byte = r_addr;
        if (i_Tx_Done) w_state_nxt = S_RESP_STAT;
      end
`endif
      S_RESP_STAT: begin
        o_Tx_Byte = r_status;
        if (!i_Tx_Busy) begin
          o_Tx_Start  = 1'b1;
          w_state_nxt = S_WAIT_STAT;
        end
      end
      S_WAIT_STAT: begin
        o_Tx_Byte = r_status;
        if (i_Tx_Done) w_state_nxt = S_RESP_DATA;
      end
      S_RESP_DATA: begin
        o_Tx_Byte = r_data;
        if (!i_Tx_Busy) begin
          o_Tx_Start  = 1'b1;
          w_state_nxt = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        o_Tx_Byte = r_data;
        if (i_Tx_Done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      r_addr   <= '0;
      r_req    <= '0;
      r_status <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_cmd_load) begin
        r_addr <= w_head_addr;
        r_req  <= w_head_req;
      end
      if (w_resp_load) begin
        r_status <= w_status_nxt;
        r_data   <= w_data_nxt;
      end
      if (r_state == S_START)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_Busy     = (r_state != S_IDLE);
  assign o_Overflow = r_overflow;

endmodule
